div_operand_packer: RTL and testbench
=====================================

Name: div_operand_packer

Overview:
Sits between the rah_decoder app queue and the divider datapath inside a divider app, all in the rx_pixel_clk domain. It pops two 48-bit RAH words (dividend, divisor) from the decoder queue and issues one divide command over a valid/ready handshake. It captures the quotient and remainder and pushes two 48-bit result words into the rah_encoder write FIFO. Divide-by-zero is handled locally without using the divider.

Parameters:
DATA_WIDTH, 48, RAH packet width; must be >= OPERAND_WIDTH+16
OPERAND_WIDTH, 32, dividend/divisor/quotient/remainder width
TIMEOUT_CYCLES, 1024, result watchdog limit (used only with PACKER_TIMEOUT_EN)

Ports:
clk  in  1  rx_pixel_clk domain clock
rst  in  1  asynchronous active-high reset
q_data  in  DATA_WIDTH  decoder queue read data; valid the cycle after rd_en
q_empty  in  1  decoder queue empty
rd_en  out  1  queue pop request
div_valid  out  1  command valid to divider
div_ready  in  1  divider accepts command
div_dividend  out  OPERAND_WIDTH  dividend
div_divisor  out  OPERAND_WIDTH  divisor
res_valid  in  1  one-cycle result strobe from divider
res_quotient  in  OPERAND_WIDTH  quotient
res_remainder  in  OPERAND_WIDTH  remainder
wr_en  out  1  encoder FIFO write strobe
wr_data  out  DATA_WIDTH  encoder FIFO write data
wr_full  in  1  encoder FIFO full
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: state=IDLE. rd_en, div_valid, wr_en and busy are 0. wr_data, div_dividend, div_divisor, tag and flags are 0. Reset mid-operation abandons the transaction: no partial writes and no further pops.
- Input word format: [47:32] tag, [31:0] operand. The tag comes from word A. If word B's tag differs from word A's, set tag_err; the transaction still proceeds.
- FSM:
  - IDLE: if !q_empty, assert rd_en for 1 cycle, go to CAP_A.
  - CAP_A: latch dividend and tag from q_data, go to REQ_B.
  - REQ_B: wait for !q_empty, assert rd_en for 1 cycle, go to CAP_B.
  - CAP_B: latch divisor and compare tags. If divisor==0, go to ZERO; else go to ISSUE.
  - ISSUE: hold div_valid=1 with stable operands until the cycle div_ready=1, then go to WAIT_RES. A transfer occurs on div_valid&div_ready.
  - WAIT_RES: on res_valid, capture quotient and remainder, go to WR_Q. A res_valid outside WAIT_RES is ignored.
  - ZERO: set quotient={OPERAND_WIDTH{1}}, remainder=dividend, dbz=1, go to WR_Q. The divider is never issued.
  - WR_Q: when !wr_full, wr_en=1 with wr_data={tag, quotient}, go to WR_R.
  - WR_R: when !wr_full, wr_en=1 with wr_data={13'b0, to_err, tag_err, dbz, remainder}, go to IDLE and clear the flags.
- rd_en is never asserted while q_empty=1. wr_en is never asserted while wr_full=1. Each is at most 1 cycle per word.
- Minimum latency with zero divisor: first pop to second write = 7 cycles (IDLE, CAP_A, REQ_B, CAP_B, ZERO, WR_Q, WR_R).
- Back-to-back: IDLE may pop on the cycle immediately after the WR_R write.
- Width rule: upper result bits above OPERAND_WIDTH+16 are zero-filled when DATA_WIDTH > 48.

Optional Feature:
- Macro: PACKER_TIMEOUT_EN.
- Defined: a counter starts at entry to WAIT_RES. If res_valid has not arrived after TIMEOUT_CYCLES cycles, quotient=all ones, remainder=0, to_err=1, go to WR_Q. A later stray res_valid is ignored.
- Undefined: WAIT_RES waits indefinitely, to_err is constant 0, and no counter logic is synthesized.

Test Plan:
- Queue words 0x00AB_00000064 then 0x00AB_00000007; divider returns q=14, r=2 -> writes 0x00AB_0000000E then 0x0000_00000002; exactly 2 rd_en and 2 wr_en.
- Divisor word 0x00CD_00000000 with dividend 0x00CD_00000010 -> no div_valid; writes 0x00CD_FFFFFFFF then 0x0001_00000010 (dbz bit 32 set).
- Tag mismatch (A tag 0x0001, B tag 0x0002, 9/3) -> writes 0x0001_00000003 then 0x0002_00000000 (tag_err bit 33).
- Hold div_ready=0 for 5 cycles -> div_valid stays high with stable operands and no extra pops; wr_full=1 for 4 cycles in WR_Q -> wr_en stays 0 and wr_data is held.
- Assert rst during WAIT_RES -> all outputs return to 0 immediately; a following res_valid produces no write; the next transaction completes normally.
- With PACKER_TIMEOUT_EN and TIMEOUT_CYCLES=16, no res_valid -> after 16 cycles writes {tag, 0xFFFFFFFF} then 0x0004_00000000 (to_err bit 34).

Source files
------------

// File: rtl/div_operand_packer.sv
// Pops a dividend/divisor word pair from the decoder queue, issues one divide and pushes
// quotient/status words to the encoder FIFO. Optional result watchdog: PACKER_TIMEOUT_EN.
module div_operand_packer #(
  parameter int unsigned DATA_WIDTH     = 48,
  parameter int unsigned OPERAND_WIDTH  = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    q_data,
  input  logic                     q_empty,
  output logic                     rd_en,
  output logic                     div_valid,
  input  logic                     div_ready,
  output logic [OPERAND_WIDTH-1:0] div_dividend,
  output logic [OPERAND_WIDTH-1:0] div_divisor,
  input  logic                     res_valid,
  input  logic [OPERAND_WIDTH-1:0] res_quotient,
  input  logic [OPERAND_WIDTH-1:0] res_remainder,
  output logic                     wr_en,
  output logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     wr_full,
  output logic                     busy
);

  typedef enum logic [3:0] {
    StIdle, StCapA, StReqB, StCapB, StIssue, StWaitRes, StZero, StWrQ, StWrR
  } state_e;

  state_e r_state, w_state_next;

  logic [15:0]              r_tag;
  logic [OPERAND_WIDTH-1:0] r_dividend, r_divisor, r_quot, r_rem;
  logic                     r_tag_err, r_dbz;
  logic                     w_timeout, w_to_err;
  logic [15:0]              w_q_tag;
  logic [OPERAND_WIDTH-1:0] w_q_operand;

  assign w_q_tag     = q_data[OPERAND_WIDTH +: 16];
  assign w_q_operand = q_data[OPERAND_WIDTH-1:0];

`ifdef PACKER_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] r_to_cnt;
  logic            r_to_err;

  // Fires on the last allowed WAIT_RES cycle when no result is present.
  assign w_timeout = (r_state == StWaitRes) && !res_valid &&
                     (r_to_cnt == CntW'(TIMEOUT_CYCLES - 1));
  assign w_to_err  = r_to_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt <= '0;
      r_to_err <= 1'b0;
    end else begin
      r_to_cnt <= (r_state == StWaitRes) ? r_to_cnt + 1'b1 : '0;
      if (w_timeout) begin
        r_to_err <= 1'b1;
      end else if (r_state == StWrR && !wr_full) begin
        r_to_err <= 1'b0;
      end
    end
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYCLES == 0);
  assign w_timeout    = 1'b0;
  assign w_to_err     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:    if (!q_empty) w_state_next = StCapA;
      StCapA:    w_state_next = StReqB;
      StReqB:    if (!q_empty) w_state_next = StCapB;
      StCapB:    w_state_next = (w_q_operand == '0) ? StZero : StIssue;
      StIssue:   if (div_ready) w_state_next = StWaitRes;
      StWaitRes: if (res_valid || w_timeout) w_state_next = StWrQ;
      StZero:    w_state_next = StWrQ;
      StWrQ:     if (!wr_full) w_state_next = StWrR;
      StWrR:     if (!wr_full) w_state_next = StIdle;
      default:   w_state_next = StIdle;
    endcase
  end

  always_comb begin
    rd_en     = !rst && !q_empty && (r_state == StIdle || r_state == StReqB);
    div_valid = (r_state == StIssue);
    wr_en     = !wr_full && (r_state == StWrQ || r_state == StWrR);
    busy      = (r_state != StIdle);
    wr_data   = '0;
    if (r_state == StWrQ) begin
      wr_data[OPERAND_WIDTH +: 16]    = r_tag;
      wr_data[OPERAND_WIDTH-1:0]      = r_quot;
    end else if (r_state == StWrR) begin
      wr_data[OPERAND_WIDTH-1:0]      = r_rem;
      wr_data[OPERAND_WIDTH]          = r_dbz;
      wr_data[OPERAND_WIDTH + 1]      = r_tag_err;
      wr_data[OPERAND_WIDTH + 2]      = w_to_err;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag      <= '0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_tag_err  <= 1'b0;
      r_dbz      <= 1'b0;
    end else begin
      unique case (r_state)
        StCapA: begin
          r_dividend <= w_q_operand;
          r_tag      <= w_q_tag;
        end
        StCapB: begin
          r_divisor <= w_q_operand;
          r_tag_err <= (w_q_tag != r_tag);
        end
        StWaitRes: begin
          if (res_valid) begin
            r_quot <= res_quotient;
            r_rem  <= res_remainder;
          end else if (w_timeout) begin
            r_quot <= '1;
            r_rem  <= '0;
          end
        end
        StZero: begin
          // Divide-by-zero is resolved here; the divider never sees it.
          r_quot <= '1;
          r_rem  <= r_dividend;
          r_dbz  <= 1'b1;
        end
        StWrR: begin
          if (!wr_full) begin
            r_tag_err <= 1'b0;
            r_dbz     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign div_dividend = r_dividend;
  assign div_divisor  = r_divisor;

endmodule

// File: tb/tb_div_operand_packer.sv
// Randomised bench for div_operand_packer: emulates the decoder queue, divider and encoder
// FIFO, and checks every write and command against an arithmetic model of the transfer.
module tb_div_operand_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] q_data;
  logic        q_empty;
  logic        rd_en;
  logic        div_valid;
  logic        div_ready;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic        res_valid;
  logic [31:0] res_quotient;
  logic [31:0] res_remainder;
  logic        wr_en;
  logic [47:0] wr_data;
  logic        wr_full;
  logic        busy;

  div_operand_packer #(
    .DATA_WIDTH    (48),
    .OPERAND_WIDTH (32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .q_data       (q_data),
    .q_empty      (q_empty),
    .rd_en        (rd_en),
    .div_valid    (div_valid),
    .div_ready    (div_ready),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .res_valid    (res_valid),
    .res_quotient (res_quotient),
    .res_remainder(res_remainder),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .wr_full      (wr_full),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_rd = 0;
  int n_wr = 0;
  int n_dv = 0;
  int n_take = 0;

  logic [47:0] qmem[$];
  logic [47:0] exp_wr[$];
  logic [63:0] exp_cmd[$];

  int ready_mode = 0;  // 0 random, 1 forced low, 2 forced high
  int full_mode = 0;   // 0 random, 1 forced full, 2 forced not full
  bit div_mute = 1'b0;
  bit stray_req = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  function automatic void expect_pair(input logic [47:0] a, input logic [47:0] b);
    logic [15:0] tag;
    logic [31:0] x, y, q, r;
    logic        te, dbz;
    tag = a[47:32];
    x   = a[31:0];
    y   = b[31:0];
    te  = (b[47:32] != tag);
    if (y == 32'd0) begin
      q   = 32'hFFFF_FFFF;
      r   = x;
      dbz = 1'b1;
    end else begin
      q   = x / y;
      r   = x % y;
      dbz = 1'b0;
      exp_cmd.push_back({x, y});
    end
    exp_wr.push_back({tag, q});
    exp_wr.push_back({13'd0, 1'b0, te, dbz, r});
  endfunction

  task automatic push_pair(input logic [47:0] a, input logic [47:0] b);
    qmem.push_back(a);
    qmem.push_back(b);
  endtask

  task automatic drain(input string name, input int budget);
    int t = 0;
    while ((exp_wr.size() != 0 || exp_cmd.size() != 0) && t < budget) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (exp_wr.size() != 0 || exp_cmd.size() != 0) begin
      n_bad++;
      $display("FAIL %s_drain: got %0d writes and %0d commands outstanding, want 0",
               name, exp_wr.size(), exp_cmd.size());
      exp_wr.delete();
      exp_cmd.delete();
      qmem.delete();
    end
    @(negedge clk);
    check({name, "_idle"}, 64'(busy), 64'd0);
  endtask

  // Queue, divider and FIFO emulation: decide on the falling edge, drive just after the rise.
  initial begin
    bit          pop, take, rsp_pend;
    int          rsp_cnt;
    logic [31:0] rsp_q, rsp_r;
    rsp_pend = 1'b0;
    rsp_cnt  = 0;
    rsp_q    = '0;
    rsp_r    = '0;
    forever begin
      @(negedge clk);
      pop  = (rd_en === 1'b1) && !rst;
      take = div_valid && div_ready && !rst;
      if (take && !div_mute) begin
        rsp_pend = 1'b1;
        rsp_cnt  = $urandom_range(1, 6);
        rsp_q    = (div_divisor != 0) ? div_dividend / div_divisor : 32'hFFFF_FFFF;
        rsp_r    = (div_divisor != 0) ? div_dividend % div_divisor : div_dividend;
      end
      @(posedge clk);
      #1;
      if (rst) rsp_pend = 1'b0;
      if (pop && qmem.size() > 0) q_data = qmem.pop_front();
      res_valid = 1'b0;
      if (rsp_pend) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          res_valid     = 1'b1;
          res_quotient  = rsp_q;
          res_remainder = rsp_r;
          rsp_pend      = 1'b0;
        end
      end else if (stray_req || (!div_mute && $urandom_range(0, 7) == 0)) begin
        res_valid     = 1'b1;
        res_quotient  = $urandom;
        res_remainder = $urandom;
        stray_req     = 1'b0;
      end
      div_ready = (ready_mode == 1) ? 1'b0 : (ready_mode == 2) ? 1'b1 :
                  ($urandom_range(0, 2) != 0);
      wr_full   = (full_mode == 1) ? 1'b1 : (full_mode == 2) ? 1'b0 :
                  ($urandom_range(0, 3) == 0);
      q_empty   = (qmem.size() == 0) || ($urandom_range(0, 4) == 0);
    end
  end

  // Compare process: protocol rules plus command and write contents every cycle.
  initial begin
    logic        pv_stall;
    logic [63:0] pv_ops;
    pv_stall = 1'b0;
    pv_ops   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv_stall = 1'b0;
        continue;
      end
      if (rd_en) begin
        n_rd++;
        check("rd_en_while_empty", 64'(q_empty), 64'd0);
      end
      if (div_valid) n_dv++;
      if (pv_stall) begin
        check("div_valid_held", 64'(div_valid), 64'd1);
        check("div_ops_stable", {div_dividend, div_divisor}, pv_ops);
      end
      if (div_valid && div_ready) begin
        n_take++;
        if (exp_cmd.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_cmd: got %h, want no command", {div_dividend, div_divisor});
        end else begin
          check("cmd_ops", {div_dividend, div_divisor}, exp_cmd.pop_front());
        end
      end
      pv_stall = div_valid && !div_ready;
      pv_ops   = {div_dividend, div_divisor};
      if (wr_en) begin
        n_wr++;
        check("wr_en_while_full", 64'(wr_full), 64'd0);
        if (exp_wr.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: got %h, want no write", wr_data);
        end else begin
          check("wr_data", 64'(wr_data), 64'(exp_wr.pop_front()));
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got simulation still running, want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          r0, w0, d0, c0, t;
    logic [63:0] ops;
    rst = 1'b1;
    q_empty = 1'b1;
    q_data = '0;
    div_ready = 1'b0;
    res_valid = 1'b0;
    res_quotient = '0;
    res_remainder = '0;
    wr_full = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rd_en", 64'(rd_en), 64'd0);
    check("rst_div_valid", 64'(div_valid), 64'd0);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_wr_data", 64'(wr_data), 64'd0);
    check("rst_ops", {div_dividend, div_divisor}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic divide: 100 / 7.
    r0 = n_rd;
    w0 = n_wr;
    push_pair(48'h00AB_0000_0064, 48'h00AB_0000_0007);
    exp_cmd.push_back({32'd100, 32'd7});
    exp_wr.push_back(48'h00AB_0000_000E);
    exp_wr.push_back(48'h0000_0000_0002);
    drain("t1_basic", 300);
    check("t1_pops", 64'(n_rd - r0), 64'd2);
    check("t1_writes", 64'(n_wr - w0), 64'd2);

    // Divide by zero never reaches the divider.
    d0 = n_dv;
    push_pair(48'h00CD_0000_0010, 48'h00CD_0000_0000);
    exp_wr.push_back(48'h00CD_FFFF_FFFF);
    exp_wr.push_back(48'h0001_0000_0010);
    drain("t2_dbz", 300);
    check("t2_no_div_valid", 64'(n_dv - d0), 64'd0);

    // Tag mismatch.
    push_pair(48'h0001_0000_0009, 48'h0002_0000_0003);
    exp_cmd.push_back({32'd9, 32'd3});
    exp_wr.push_back(48'h0001_0000_0003);
    exp_wr.push_back(48'h0002_0000_0000);
    drain("t3_tag_err", 300);

    // Stalled divider handshake, then a full FIFO at the quotient write.
    ready_mode = 1;
    full_mode = 1;
    push_pair(48'h0077_0000_03E8, 48'h0077_0000_0009);
    expect_pair(48'h0077_0000_03E8, 48'h0077_0000_0009);
    t = 0;
    while (!div_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("t4_reach_issue", 64'(div_valid), 64'd1);
    ops = {div_dividend, div_divisor};
    r0 = n_rd;
    repeat (5) begin
      @(negedge clk);
      check("t4_dv_held", 64'(div_valid), 64'd1);
      check("t4_ops_held", {div_dividend, div_divisor}, ops);
    end
    check("t4_no_extra_pop", 64'(n_rd - r0), 64'd0);
    ready_mode = 0;
    t = 0;
    while (wr_data !== 48'h0077_0000_006F && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("t4_reach_wrq", 64'(wr_data), 64'h0077_0000_006F);
    repeat (4) begin
      @(negedge clk);
      check("t4_wr_blocked", 64'(wr_en), 64'd0);
      check("t4_wr_data_held", 64'(wr_data), 64'h0077_0000_006F);
    end
    full_mode = 0;
    drain("t4_stall", 300);

    // Reset while waiting for the result.
    div_mute = 1'b1;
    c0 = n_take;
    push_pair(48'h0042_0000_0020, 48'h0042_0000_0004);
    exp_cmd.push_back({32'h20, 32'h4});
    t = 0;
    while (n_take == c0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("t5_cmd_accepted", 64'(n_take - c0), 64'd1);
    repeat (3) @(negedge clk);
    check("t5_busy_waiting", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("t5_rst_rd_en", 64'(rd_en), 64'd0);
    check("t5_rst_div_valid", 64'(div_valid), 64'd0);
    check("t5_rst_wr_en", 64'(wr_en), 64'd0);
    check("t5_rst_busy", 64'(busy), 64'd0);
    check("t5_rst_wr_data", 64'(wr_data), 64'd0);
    check("t5_rst_ops", {div_dividend, div_divisor}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    stray_req = 1'b1;
    w0 = n_wr;
    repeat (8) @(negedge clk);
    check("t5_no_write_after_rst", 64'(n_wr - w0), 64'd0);
    div_mute = 1'b0;
    push_pair(48'h0042_0000_0030, 48'h0042_0000_0005);
    expect_pair(48'h0042_0000_0030, 48'h0042_0000_0005);
    drain("t5_recover", 300);

`ifdef PACKER_TIMEOUT_EN
    // Divider never answers: watchdog result.
    div_mute = 1'b1;
    push_pair(48'h0055_0000_0032, 48'h0055_0000_0005);
    exp_cmd.push_back({32'd50, 32'd5});
    exp_wr.push_back(48'h0055_FFFF_FFFF);
    exp_wr.push_back(48'h0004_0000_0000);
    drain("t6_timeout", 300);
    div_mute = 1'b0;
`endif

    // Randomised traffic: first a back-to-back burst, then with gaps.
    for (int i = 0; i < 60; i++) begin
      logic [15:0] ta, tb;
      logic [31:0] x, y;
      int          sel;
      ta = 16'($urandom);
      tb = ($urandom_range(0, 4) == 0) ? 16'($urandom) : ta;
      x = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 100)) : 32'($urandom);
      sel = $urandom_range(0, 5);
      case (sel)
        0:       y = 32'd0;
        1:       y = 32'($urandom_range(1, 15));
        2:       y = (x == 0) ? 32'd1 : x;
        3:       y = 32'd1;
        default: y = 32'($urandom);
      endcase
      push_pair({ta, x}, {tb, y});
      expect_pair({ta, x}, {tb, y});
      if (i >= 30) repeat ($urandom_range(0, 12)) @(negedge clk);
    end
    drain("rand", 6000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
